// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Multi-channel push-button synchroniser, debouncer and edge-pulse
//            generator. Optional auto-repeat is enabled by BUTTON_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] Bi,
  output logic [NUM_BTN-1:0] Held,
  output logic [NUM_BTN-1:0] Press,
  output logic [NUM_BTN-1:0] Release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] c_DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] c_PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;
`endif

  generate
    if (NUM_BTN < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("button_conditioner: illegal parameter value");
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_nxt;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic                   r_held;
      logic                   r_press;
      logic                   r_release;
      logic                   w_held_nxt;
      logic                   w_press_nxt;
      logic                   w_release_nxt;
      logic                   w_s;
      logic                   w_accept;
`ifdef BUTTON_AUTOREPEAT_EN
      logic [TMR_W-1:0]       r_timer;
      logic [TMR_W-1:0]       w_timer_nxt;
`endif

      assign w_s      = r_sync[SYNC_STAGES-1];
      // A new level is accepted once it has differed from Held for DEBOUNCE_CYCLES samples.
      assign w_accept = (w_s != r_held) && (r_cnt == c_CNT_LAST);

      always_comb begin
        w_cnt_nxt     = '0;
        w_state_nxt   = r_state;
        w_held_nxt    = r_held;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        w_timer_nxt   = r_timer;
`endif
        if ((w_s != r_held) && !w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              w_state_nxt = ST_HELD;
              w_held_nxt  = 1'b1;
              w_press_nxt = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
              w_timer_nxt = '0;
`endif
            end
          end
          ST_HELD: begin
            if (w_accept) begin
              w_state_nxt   = ST_IDLE;
              w_held_nxt    = 1'b0;
              w_release_nxt = 1'b1;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            else if (r_timer == c_DLY_LAST) begin
              w_state_nxt = ST_REPEAT;
              w_press_nxt = 1'b1;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
`endif
          end
`ifdef BUTTON_AUTOREPEAT_EN
          ST_REPEAT: begin
            // Release takes priority over a repeat falling due on the same cycle.
            if (w_accept) begin
              w_state_nxt   = ST_IDLE;
              w_held_nxt    = 1'b0;
              w_release_nxt = 1'b1;
            end else if (r_timer == c_PER_LAST) begin
              w_press_nxt = 1'b1;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
          end
`endif
          default: begin
            w_state_nxt = ST_IDLE;
            w_held_nxt  = 1'b0;
          end
        endcase
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_sync    <= '0;
          r_cnt     <= '0;
          r_state   <= ST_IDLE;
          r_held    <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
          r_timer   <= '0;
`endif
        end else begin
          r_sync    <= {r_sync[SYNC_STAGES-2:0], Bi[i]};
          r_cnt     <= w_cnt_nxt;
          r_state   <= w_state_nxt;
          r_held    <= w_held_nxt;
          r_press   <= w_press_nxt;
          r_release <= w_release_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
          r_timer   <= w_timer_nxt;
`endif
        end
      end

      assign Held[i]    = r_held;
      assign Press[i]   = r_press;
      assign Release[i] = r_release;
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel push-button front end: synchronises NUM_BTN asynchronous button inputs, debounces each with its own counter, and produces a clean held level plus single-cycle press and release pulses per channel. Optional auto-repeat emits further press pulses while a button stays held. Sits between the board pushbuttons and the processor control/FSM logic, and replaces single-channel, un-debounced one-shot synchronisers.

## Interface
Parameters:
- NUM_BTN, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 500000: consecutive cycles a new synchronised value must persist before it is accepted (≥1).
- REPEAT_DELAY, 25000000: cycles from an accepted press to the first repeat pulse (≥1; used only with auto-repeat).
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses (≥1; used only with auto-repeat).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately.
- Bi  input  NUM_BTN  raw button inputs, asynchronous, active-high.
- Held  output  NUM_BTN  debounced level per channel.
- Press  output  NUM_BTN  one-cycle pulse on accepted press (and on each repeat when enabled).
- Release  output  NUM_BTN  one-cycle pulse on accepted release.

## Operation
- Channels are fully independent; no shared counters; all outputs registered.
- Sync chain: Bi[i] passes through SYNC_STAGES flops, reset 0; last flop is s[i].
- Debounce: per-channel counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - s[i] == Held[i]: cnt[i] <= 0.
  - s[i] != Held[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
  - s[i] != Held[i] and cnt[i] == DEBOUNCE_CYCLES-1: Held[i] <= s[i], cnt[i] <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count; Held does not change.
- Press[i] high for the single cycle in which Held[i] first reads 1; Release[i] likewise when Held[i] first reads 0. Press and Release on the same channel never assert together.
- Per-channel FSM: IDLE (Held=0) -> HELD on accepted press; HELD -> IDLE on accepted release. With auto-repeat: HELD -> REPEAT when the repeat timer expires; REPEAT -> IDLE on accepted release.
- Repeat timer (auto-repeat only): per-channel, cleared on the Press cycle; in HELD, a repeat Press pulse fires REPEAT_DELAY cycles after the initial Press; in REPEAT, every REPEAT_PERIOD cycles thereafter. Release wins over a repeat due in the same cycle.

## Timing
- Reset values: Held, Press, Release, sync flops, counters, timers = 0; FSM = IDLE. Reset asserted mid-debounce or mid-repeat aborts it; no Release pulse is generated by reset.
- Press latency: if Bi[i] is first sampled high at rising edge 1 and stays high, Held[i] and Press[i] go high after edge SYNC_STAGES+DEBOUNCE_CYCLES; Press drops after the next edge. Release latency is identical.
- After Reset deasserts with Bi already high, the press is accepted with the same latency (no press is lost).
- Minimum accepted pulse: DEBOUNCE_CYCLES stable cycles at s[i]; Bi activity shorter than that produces no output.
- Simultaneous presses on several channels each produce their own Press in the same cycle.

## Configuration
- BUTTON_AUTOREPEAT_EN defined: REPEAT state and per-channel repeat timers built; Press emits repeat pulses as above.
- BUTTON_AUTOREPEAT_EN undefined: no timers or REPEAT state; REPEAT_DELAY/REPEAT_PERIOD ignored; exactly one Press per accepted press.

## Test plan
Bench uses NUM_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset asserted with Bi=4'b1111 -> all outputs 0 during reset; after deassert, Press=4'b1111 exactly one cycle after edge 6, Held=4'b1111 thereafter.
- Bi[0] high at edge 1, held 20 cycles, then low (macro off) -> one Press[0] after edge 6, Held[0] high, one Release[0] 6 edges after the falling sample, no other pulses.
- Bi[1] bounce 1,0,1,0 per cycle then steady 1 -> no Press until 4 consecutive high samples at s[1]; exactly one Press[1].
- Bi[2] high 3 cycles then low -> Held[2], Press[2], Release[2] stay 0.
- BUTTON_AUTOREPEAT_EN defined, Bi[3] held 30 cycles -> Press[3] at initial cycle t, then t+8, t+11, t+14, …; release -> Release[3] once, repeats stop.
- Reset pulsed while Held[0]=1 and repeating -> Held/Press/Release clear asynchronously, no Release pulse; press re-accepted after release of reset.
